veririsc_sequencer: RTL and testbench

- Control and fetch stage directly upstream of the VeriRISC program/data memory.
- Owns the 8-phase instruction cycle, program counter (PC) and instruction register (IR).
- Drives the memory address, rd, wr and the shared bidirectional data bus.
- Accumulator and ALU are external: this block supplies the ALU opcode and ld_ac, and takes the accumulator value plus the zero flag.

---
 rtl/veririsc_pkg.sv | 46 ++++
 rtl/veririsc_pc.sv | 27 ++
 rtl/veririsc_sequencer.sv | 143 ++++++++++++++
 tb/tb_veririsc_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/veririsc_pkg.sv
// Shared constants for the VeriRISC control/fetch slice: field widths,
// opcode encodings, instruction-cycle phase numbers and the decode bundle.
package veririsc_pkg;

  localparam int OPCODE_WIDTH = 3;
  localparam int ADDR_WIDTH   = 5;

  // Opcode encodings carried in the upper instruction field
  localparam logic [OPCODE_WIDTH-1:0] HLT = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] ADD = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] AND = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] XOR = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] LDA = 3'd5;
  localparam logic [OPCODE_WIDTH-1:0] STO = 3'd6;
  localparam logic [OPCODE_WIDTH-1:0] JMP = 3'd7;

  // Phases of the eight-step instruction cycle
  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  // Raw per-phase control strobes before halt/reset gating
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Instructions that read an operand and update the accumulator
  function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/veririsc_pc.sv
// Program counter: loadable, wrapping up-counter with synchronous reset.
// A load takes precedence over an increment if both ever arrive together.
module veririsc_pc
  import veririsc_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             ld,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  // Reset to zero, jump on load, otherwise step and wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (ld) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/veririsc_sequencer.sv
// VeriRISC sequencer: runs the eight-phase instruction cycle, holds the PC
// and IR, and drives the memory address, strobes and shared data bus. The
// accumulator and ALU live outside; this block hands them the opcode and a
// load strobe and receives the accumulator value and its zero flag.
module veririsc_sequencer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  inout  wire  [DATA_WIDTH-1:0]   mem_data,
  input  logic [DATA_WIDTH-1:0]   ac_in,
  input  logic                    zero,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic                    ld_ac,
  input  logic                    resume,
  output logic                    halted,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic [2:0]              phase
);

  import veririsc_pkg::*;

  logic [2:0]              phase_q;
  logic                    halted_q;
  logic [DATA_WIDTH-1:0]   ir;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [ADDR_WIDTH-1:0]   operand;
  ctrl_t                   ctl;
  logic                    bus_block;
  logic                    data_e;
  logic                    pc_inc;
  logic                    pc_ld;

  assign opcode  = ir[DATA_WIDTH-1:ADDR_WIDTH];
  assign operand = ir[ADDR_WIDTH-1:0];

  // Per-phase decode of the raw control strobes from the phase and opcode
  always_comb begin
    ctl = '0;
    case (phase_q)
      INST_ADDR: begin
        ctl.sel = 1'b1;
      end
      INST_FETCH: begin
        ctl.sel = 1'b1;
        ctl.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        ctl.sel   = 1'b1;
        ctl.rd    = 1'b1;
        ctl.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        if (opcode == HLT) begin
          ctl.halt = 1'b1;
        end else begin
          ctl.inc_pc = 1'b1;
        end
      end
      OP_FETCH: begin
        ctl.rd = is_aluop(opcode);
      end
      ALU_OP: begin
        ctl.rd     = is_aluop(opcode);
        ctl.ld_ac  = is_aluop(opcode);
        ctl.inc_pc = (opcode == SKZ) && zero;
        ctl.ld_pc  = (opcode == JMP);
        ctl.data_e = (opcode == STO);
      end
      STORE: begin
        ctl.rd     = is_aluop(opcode);
        ctl.ld_ac  = is_aluop(opcode);
        ctl.ld_pc  = (opcode == JMP);
        ctl.data_e = (opcode == STO);
        ctl.wr     = (opcode == STO);
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

  // Memory and accumulator strobes are silenced while halted or in reset,
  // so a reset landing on STORE cannot complete the write.
  assign bus_block = rst | halted_q;
  assign mem_rd    = ctl.rd     & ~bus_block;
  assign mem_wr    = ctl.wr     & ~bus_block;
  assign ld_ac     = ctl.ld_ac  & ~bus_block;
  assign data_e    = ctl.data_e & ~bus_block;

  assign mem_data   = data_e ? ac_in : 'z;
  assign mem_addr   = ctl.sel ? pc : operand;
  assign alu_opcode = opcode;
  assign halted     = halted_q;
  assign phase      = phase_q;

  // While halted the only PC activity is the step taken on resume
  assign pc_inc = halted_q ? resume : ctl.inc_pc;
  assign pc_ld  = ~halted_q & ctl.ld_pc;

  veririsc_pc #(
    .WIDTH(ADDR_WIDTH)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc       (pc_inc),
    .ld        (pc_ld),
    .load_value(operand),
    .count     (pc)
  );

  // Phase sequencing and halt: freeze at OP_ADDR on HLT, resume into OP_FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else if (halted_q) begin
      if (resume) begin
        halted_q <= 1'b0;
        phase_q  <= OP_FETCH;
      end
    end else if (ctl.halt) begin
      halted_q <= 1'b1;
    end else begin
      phase_q <= phase_q + 3'd1;
    end
  end

  // Instruction register captures the registered memory read data
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= '0;
    end else if (ctl.ld_ir && !halted_q) begin
      ir <= mem_data;
    end
  end

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Directed bench for veririsc_sequencer: a small registered-read memory
// model, a per-cycle vector table covering LDA/STO/SKZ/JMP, and hand-written
// sequences for SKZ taken, PC wrap, HLT/resume and reset during STORE.
module tb_veririsc_sequencer;

  typedef struct packed {
    logic       zero;
    logic [7:0] ac;
    logic [2:0] ph;
    logic [4:0] pcv;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic       ldac;
    logic       drv;
    logic [2:0] opc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       zero;
  logic       resume;
  logic [7:0] ac_in;
  wire  [7:0] mem_data;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic       ld_ac;
  logic       halted;
  logic [2:0] alu_opcode;
  logic [2:0] phase;
  logic [4:0] pc;

  logic [7:0] mem [0:31];
  logic [7:0] rdata;
  logic       rd_q;
  logic       poke_en;
  logic [4:0] poke_addr;
  logic [7:0] poke_data;

  int checks = 0;
  int fails  = 0;

  vec_t vecs [0:32];

  veririsc_sequencer #(
    .ADDR_WIDTH  (5),
    .DATA_WIDTH  (8),
    .OPCODE_WIDTH(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_data  (mem_data),
    .ac_in     (ac_in),
    .zero      (zero),
    .alu_opcode(alu_opcode),
    .ld_ac     (ld_ac),
    .resume    (resume),
    .halted    (halted),
    .pc        (pc),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Memory with registered read: data for a read in one cycle appears the next
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_data;
    end
    rd_q  <= mem_rd;
    rdata <= mem[mem_addr];
  end

  assign mem_data = rd_q ? rdata : 8'hzz;

  function automatic vec_t mk(input int z, input int ac, input int ph, input int pcv,
                              input int addr, input int rd, input int wr,
                              input int ldac, input int drv, input int opc);
    vec_t v;
    v.zero = z[0];
    v.ac   = ac[7:0];
    v.ph   = ph[2:0];
    v.pcv  = pcv[4:0];
    v.addr = addr[4:0];
    v.rd   = rd[0];
    v.wr   = wr[0];
    v.ldac = ldac[0];
    v.drv  = drv[0];
    v.opc  = opc[2:0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkBusIdle(input string name, input logic [7:0] ac);
    checks++;
    if (mem_data === ac) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected bus not driven with %0h (t=%0t)",
               name, mem_data, ac, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    zero   = v.zero;
    ac_in  = v.ac;
    resume = 1'b0;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, "_phase"},  32'(phase),      32'(v.ph));
    checkOutput({tag, "_pc"},     32'(pc),         32'(v.pcv));
    checkOutput({tag, "_addr"},   32'(mem_addr),   32'(v.addr));
    checkOutput({tag, "_rd"},     32'(mem_rd),     32'(v.rd));
    checkOutput({tag, "_wr"},     32'(mem_wr),     32'(v.wr));
    checkOutput({tag, "_ld_ac"},  32'(ld_ac),      32'(v.ldac));
    checkOutput({tag, "_opcode"}, 32'(alu_opcode), 32'(v.opc));
    checkOutput({tag, "_halted"}, 32'(halted),     32'd0);
    if (v.drv) begin
      checkOutput({tag, "_bus"}, 32'(mem_data), 32'(v.ac));
    end else if (!rd_q) begin
      checkBusIdle({tag, "_bus_idle"}, v.ac);
    end
  endtask

  task automatic pokeMem(input logic [4:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitPhase(input logic [2:0] ph, input logic [2:0] opc, input string tag);
    int n;
    n = 0;
    while (!(phase == ph && alu_opcode == opc) && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_reached"}, 32'(phase == ph && alu_opcode == opc), 32'd1);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Program: LDA 0x10, STO 0x11, SKZ, JMP 8 ; at 8: SKZ ; at 10: JMP 0x1F ; at 0x1F: LDA 0x10
    vecs[0]  = mk(0, 'h5A, 0, 'h00, 'h00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 'h5A, 1, 'h00, 'h00, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 'h5A, 2, 'h00, 'h00, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 'h5A, 3, 'h00, 'h00, 1, 0, 0, 0, 5);
    vecs[4]  = mk(0, 'h5A, 4, 'h00, 'h10, 0, 0, 0, 0, 5);
    vecs[5]  = mk(0, 'h5A, 5, 'h01, 'h10, 1, 0, 0, 0, 5);
    vecs[6]  = mk(0, 'h5A, 6, 'h01, 'h10, 1, 0, 1, 0, 5);
    vecs[7]  = mk(0, 'h5A, 7, 'h01, 'h10, 1, 0, 1, 0, 5);
    vecs[8]  = mk(1, 'h5A, 0, 'h01, 'h01, 0, 0, 0, 0, 5);
    vecs[9]  = mk(1, 'h5A, 1, 'h01, 'h01, 1, 0, 0, 0, 5);
    vecs[10] = mk(1, 'h5A, 2, 'h01, 'h01, 1, 0, 0, 0, 5);
    vecs[11] = mk(1, 'h5A, 3, 'h01, 'h01, 1, 0, 0, 0, 6);
    vecs[12] = mk(1, 'h5A, 4, 'h01, 'h11, 0, 0, 0, 0, 6);
    vecs[13] = mk(1, 'h5A, 5, 'h02, 'h11, 0, 0, 0, 0, 6);
    vecs[14] = mk(1, 'h5A, 6, 'h02, 'h11, 0, 0, 0, 1, 6);
    vecs[15] = mk(1, 'h5A, 7, 'h02, 'h11, 0, 1, 0, 1, 6);
    vecs[16] = mk(0, 'h5A, 0, 'h02, 'h02, 0, 0, 0, 0, 6);
    vecs[17] = mk(0, 'h5A, 1, 'h02, 'h02, 1, 0, 0, 0, 6);
    vecs[18] = mk(0, 'h5A, 2, 'h02, 'h02, 1, 0, 0, 0, 6);
    vecs[19] = mk(0, 'h5A, 3, 'h02, 'h02, 1, 0, 0, 0, 1);
    vecs[20] = mk(0, 'h5A, 4, 'h02, 'h00, 0, 0, 0, 0, 1);
    vecs[21] = mk(0, 'h5A, 5, 'h03, 'h00, 0, 0, 0, 0, 1);
    vecs[22] = mk(0, 'h5A, 6, 'h03, 'h00, 0, 0, 0, 0, 1);
    vecs[23] = mk(0, 'h5A, 7, 'h03, 'h00, 0, 0, 0, 0, 1);
    vecs[24] = mk(0, 'h5A, 0, 'h03, 'h03, 0, 0, 0, 0, 1);
    vecs[25] = mk(0, 'h5A, 1, 'h03, 'h03, 1, 0, 0, 0, 1);
    vecs[26] = mk(0, 'h5A, 2, 'h03, 'h03, 1, 0, 0, 0, 1);
    vecs[27] = mk(0, 'h5A, 3, 'h03, 'h03, 1, 0, 0, 0, 7);
    vecs[28] = mk(0, 'h5A, 4, 'h03, 'h08, 0, 0, 0, 0, 7);
    vecs[29] = mk(0, 'h5A, 5, 'h04, 'h08, 0, 0, 0, 0, 7);
    vecs[30] = mk(0, 'h5A, 6, 'h04, 'h08, 0, 0, 0, 0, 7);
    vecs[31] = mk(0, 'h5A, 7, 'h08, 'h08, 0, 0, 0, 0, 7);
    vecs[32] = mk(0, 'h5A, 0, 'h08, 'h08, 0, 0, 0, 0, 7);

    rst       = 1'b1;
    zero      = 1'b0;
    resume    = 1'b0;
    ac_in     = 8'h5A;
    poke_en   = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    @(negedge clk);

    // Program load happens while reset is held (well over two cycles)
    pokeMem(5'h00, 8'hB0);
    pokeMem(5'h01, 8'hD1);
    pokeMem(5'h02, 8'h20);
    pokeMem(5'h03, 8'hE8);
    pokeMem(5'h08, 8'h20);
    pokeMem(5'h09, 8'h00);
    pokeMem(5'h0A, 8'hFF);
    pokeMem(5'h10, 8'h3C);
    pokeMem(5'h11, 8'h00);
    pokeMem(5'h1F, 8'hB0);

    #1;
    checkOutput("rst_phase",  32'(phase),      32'd0);
    checkOutput("rst_pc",     32'(pc),         32'd0);
    checkOutput("rst_addr",   32'(mem_addr),   32'd0);
    checkOutput("rst_rd",     32'(mem_rd),     32'd0);
    checkOutput("rst_wr",     32'(mem_wr),     32'd0);
    checkOutput("rst_halted", 32'(halted),     32'd0);
    checkOutput("rst_opcode", 32'(alu_opcode), 32'd0);
    checkBusIdle("rst_bus_idle", ac_in);

    rst = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) begin
        @(negedge clk);
      end
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end
    checkOutput("sto_mem_11", 32'(mem[17]), 32'h5A);

    // SKZ at 8 with zero set: skips location 9
    zero = 1'b1;
    waitPhase(3'd5, 3'd1, "skz_p5");
    checkOutput("skz_pc_p5", 32'(pc), 32'h09);
    waitPhase(3'd7, 3'd1, "skz_p7");
    checkOutput("skz_pc_p7", 32'(pc), 32'h0A);
    zero = 1'b0;

    // JMP 0x1F at 0x0A, then LDA at 0x1F wraps the PC to 0
    waitPhase(3'd7, 3'd7, "jmp1f_p7");
    checkOutput("jmp1f_pc", 32'(pc), 32'h1F);
    stepCycle();
    checkOutput("jmp1f_fetch_addr", 32'(mem_addr), 32'h1F);
    waitPhase(3'd5, 3'd5, "wrap_p5");
    checkOutput("wrap_pc", 32'(pc), 32'h00);

    // Turn location 0 into HLT and let it execute
    pokeMem(5'h00, 8'h00);
    waitPhase(3'd4, 3'd0, "hlt_p4");
    checkOutput("hlt_pre_halted", 32'(halted), 32'd0);
    for (int c = 0; c < 10; c++) begin
      stepCycle();
      checkOutput($sformatf("hlt_halted_c%0d", c), 32'(halted), 32'd1);
      checkOutput($sformatf("hlt_phase_c%0d", c),  32'(phase),  32'd4);
      checkOutput($sformatf("hlt_pc_c%0d", c),     32'(pc),     32'd0);
      checkOutput($sformatf("hlt_rd_c%0d", c),     32'(mem_rd), 32'd0);
      checkOutput($sformatf("hlt_wr_c%0d", c),     32'(mem_wr), 32'd0);
    end

    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    checkOutput("resume_halted", 32'(halted), 32'd0);
    checkOutput("resume_pc",     32'(pc),     32'd1);
    checkOutput("resume_phase",  32'(phase),  32'd5);

    // A resume pulse while running must not move the PC
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    checkOutput("stray_resume_phase",  32'(phase),  32'd6);
    checkOutput("stray_resume_pc",     32'(pc),     32'd1);
    checkOutput("stray_resume_halted", 32'(halted), 32'd0);

    // STO at 1 again, with reset landing in STORE
    pokeMem(5'h11, 8'h33);
    ac_in = 8'h77;
    waitPhase(3'd6, 3'd6, "sto2_p6");
    checkOutput("sto2_bus_p6", 32'(mem_data), 32'h77);
    checkOutput("sto2_rd_p6",  32'(mem_rd),   32'd0);
    stepCycle();
    checkOutput("sto2_phase_p7", 32'(phase),  32'd7);
    checkOutput("sto2_wr_p7",    32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_sto_wr",    32'(mem_wr), 32'd0);
    checkOutput("rst_sto_ld_ac", 32'(ld_ac),  32'd0);
    checkBusIdle("rst_sto_bus_idle", ac_in);
    stepCycle();
    checkOutput("rst_sto_mem_11", 32'(mem[17]),   32'h33);
    checkOutput("rst_sto_phase",  32'(phase),      32'd0);
    checkOutput("rst_sto_pc",     32'(pc),         32'd0);
    checkOutput("rst_sto_opcode", 32'(alu_opcode), 32'd0);
    checkOutput("rst_sto_halted", 32'(halted),     32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
